sprite_line_renderer: RTL and testbench
=======================================

Name: sprite_line_renderer

Overview:
- Initiator for the sprite pixel ROM bank. Takes the sprite number, row and pixel column, and expects a 4-bit colour code back.
- Once per scanline, it walks the sprite attribute table and finds every sprite that intersects the requested line.
- For each such sprite, it fetches the sprite's 32 pixels from the ROM bank and writes the non-transparent ones into a scanline buffer.
- The scanline buffer is consumed by the colour palette stage during the next line's display.

Parameters:
- N_SPR, 32, number of attribute table entries (index width clog2(N_SPR)).
- SPR_W, 32, sprite width in pixels (power of two; ROM row stride).
- SPR_H, 32, sprite height in rows.
- LINE_W, 640, visible pixels per line; writes at x >= LINE_W are clipped.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins rendering of line_num; ignored while busy.
- line_num  in  10  target scanline, sampled on an accepted start.
- attr_addr  out  clog2(N_SPR)  attribute table read index.
- attr_rd  out  1  attribute read strobe.
- attr_data  in  26  {y[25:16], x[15:6], n_sprite[5:0]}; valid exactly 1 cycle after attr_rd.
- n_sprite  out  6  sprite ROM select (0 = no sprite).
- line  out  10  sprite row to the ROM, zero-extended.
- pixel  out  6  sprite column to the ROM.
- color_code  in  4  ROM data; valid exactly 1 cycle after n_sprite/line/pixel.
- lb_we  out  1  scanline buffer write enable.
- lb_addr  out  10  scanline buffer x address.
- lb_data  out  4  colour code written.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the line is complete.

Behaviour:
- Reset values:
  - All outputs 0; FSM in IDLE; sprite index 0.
  - Reset asserted mid-line aborts the line: next cycle is IDLE and no further lb_we occurs.
  - No done pulse is issued for an aborted line.
- State IDLE:
  - On start, latch line_num into L, clear index i to 0, and go to AREQ.
  - start while not IDLE is ignored; the latched L is unchanged.
- State AREQ:
  - attr_rd=1, attr_addr=i.
  - Go to AWAIT.
- State AWAIT:
  - Register attr_data into y, x, s.
  - Go to CHECK.
- State CHECK:
  - Visible when s != 0 and y <= L and (L - y) < SPR_H.
  - Compare in 11-bit arithmetic, so y + SPR_H does not wrap.
  - If visible: row = L - y, p = 0, go to FETCH.
  - Otherwise go to NEXT.
- State FETCH, one ROM request per cycle:
  - Drive n_sprite=s, line=row, pixel=p.
  - Advance p each cycle; after p = SPR_W-1 is issued, go to DRAIN.
- Pixel write pipeline:
  - Each request's address {x+p} is carried 1 cycle alongside it.
  - On the following cycle, lb_we = (color_code != 0) and (x+p < LINE_W), with lb_addr = x+p and lb_data = color_code.
  - x+p is computed in 11 bits; results >= LINE_W are clipped, never wrapped.
  - Colour code 0 is transparent and is never written.
- State DRAIN:
  - Completes the last pipelined write.
  - Outside FETCH/DRAIN, n_sprite=0 and lb_we=0.
- State NEXT:
  - If i == N_SPR-1, go to FIN; else i+1 and go to AREQ.
- State FIN:
  - done=1 for one cycle, busy=0 next cycle, go to IDLE.
  - A start in the FIN cycle is ignored.
- Cycle counts:
  - Visible sprite: AREQ + AWAIT + CHECK + SPR_W×FETCH + DRAIN + NEXT = SPR_W + 5 cycles.
  - Invisible sprite: 4 cycles.
  - Line total = 4·N_SPR + (SPR_W+1)·visible_count + 1 (FIN), measured from the first AREQ.
- Priority: painter's order. Sprite i+1 overwrites sprite i at the same x; the scanline buffer keeps the last write.
- Sprites with y above L, or with y+SPR_H <= L, are never fetched; no ROM traffic occurs for them.
- The block never clears the scanline buffer; clearing is the consumer's job.

Test Plan:
- Single sprite:
  - Stimulus: reset, entry 0 = {y=100, x=200, s=1}, others s=0, start with line_num=105.
  - Required ROM requests: (1, 5, 0..31) on 32 consecutive cycles.
  - Required writes: lb_addr 200..231 for every nonzero colour; no other writes.
  - Required timing: done after 4·32+33+1 = 162 cycles.
- Row bounds:
  - Stimulus: same entry, line_num=99, then 132, then 131.
  - Required: no ROM requests for 99 or 132; 131 fetches row 31.
- Right-edge clip:
  - Stimulus: entry x=620, all-ones ROM data.
  - Required: writes at lb_addr 620..639 only; 20 writes total; 12 suppressed.
- Transparency and overlap:
  - Stimulus: sprite 0 at x=10, sprite 1 at x=20, same line; ROM colour 0 in pixels 0..3 of sprite 1.
  - Required: addresses 20..23 are written only by sprite 0.
  - Required: addresses 24..41 carry sprite 1's colour, written after sprite 0's.
- Handshake abuse:
  - Stimulus: start held high for 5 cycles, then a start 10 cycles into the line.
  - Required: exactly one line rendered, one done pulse, L unchanged.
  - Stimulus: reset at cycle 50.
  - Required: next cycle busy=0, lb_we=0, no done; a fresh start then renders normally.
- Empty table:
  - Stimulus: all s=0.
  - Required: zero lb_we; done after 4·32+1 = 129 cycles.

Source files
------------

// File: rtl/sprite_line_renderer_if.sv
// Sprite line renderer bus bundle.
// Groups the renderer's control handshake, attribute-table read port,
// sprite ROM request/response port and scanline-buffer write port.
//   master : the renderer (drives requests, writes, busy/done)
//   slave  : the surrounding system (drives start, attribute data, ROM data)
// Signals:
//   start, line_num        - line render request
//   busy, done             - render status
//   attr_addr, attr_rd     - attribute table read request
//   attr_data              - {y[25:16], x[15:6], n_sprite[5:0]}, 1 cycle after attr_rd
//   n_sprite, line, pixel  - sprite ROM request (n_sprite 0 = idle)
//   color_code             - ROM data, 1 cycle after the request
//   lb_we, lb_addr, lb_data- scanline buffer write port
interface sprite_line_renderer_if #(
    parameter int N_SPR = 32
);
    localparam int IW = (N_SPR > 1) ? $clog2(N_SPR) : 1;

    logic          start;
    logic [9:0]    line_num;
    logic          busy;
    logic          done;
    logic [IW-1:0] attr_addr;
    logic          attr_rd;
    logic [25:0]   attr_data;
    logic [5:0]    n_sprite;
    logic [9:0]    line;
    logic [5:0]    pixel;
    logic [3:0]    color_code;
    logic          lb_we;
    logic [9:0]    lb_addr;
    logic [3:0]    lb_data;

    modport master (
        input  start, line_num, attr_data, color_code,
        output busy, done, attr_addr, attr_rd, n_sprite, line, pixel,
               lb_we, lb_addr, lb_data
    );

    modport slave (
        output start, line_num, attr_data, color_code,
        input  busy, done, attr_addr, attr_rd, n_sprite, line, pixel,
               lb_we, lb_addr, lb_data
    );
endinterface

// File: rtl/sprite_line_renderer.sv
// Sprite line renderer.
// On start, walks every attribute table entry once, and for each sprite that
// covers the requested scanline fetches its SPR_W pixels from the sprite ROM
// (one request per cycle) and writes the non-transparent, on-screen ones into
// the scanline buffer. Later table entries overwrite earlier ones.
// Ports:
//   clk   - system clock
//   reset - synchronous, active-high reset; aborts a line in progress
//   bus   - sprite_line_renderer_if.master (control, attribute, ROM, buffer)
module sprite_line_renderer #(
    parameter int N_SPR  = 32,
    parameter int SPR_W  = 32,
    parameter int SPR_H  = 32,
    parameter int LINE_W = 640
) (
    input  logic                   clk,
    input  logic                   reset,
    sprite_line_renderer_if.master bus
);
    localparam int IW = (N_SPR > 1) ? $clog2(N_SPR) : 1;
    localparam int PW = (SPR_W > 1) ? $clog2(SPR_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_AREQ, S_AWAIT, S_CHECK, S_FETCH, S_DRAIN, S_NEXT, S_FIN
    } state_t;

    state_t        state_q, state_d;
    logic [9:0]    l_q;          // latched target line
    logic [IW-1:0] i_q;          // attribute table index
    logic [9:0]    y_q, x_q;     // current sprite position
    logic [5:0]    s_q;          // current sprite ROM select
    logic [9:0]    row_q;        // row within the sprite
    logic [PW-1:0] p_q;          // pixel column being requested
    logic          wr_valid_q;   // a ROM request was issued last cycle
    logic [10:0]   wr_addr_q;    // its scanline x, kept unclipped

    logic [10:0]   l_ext, y_ext, x_ext, dy;
    logic          visible, last_pixel, last_index, wr_en;

    // Everything is compared in 11 bits so y + SPR_H and x + p never wrap
    // back onto the visible line.
    assign l_ext      = {1'b0, l_q};
    assign y_ext      = {1'b0, y_q};
    assign x_ext      = {1'b0, x_q};
    assign dy         = l_ext - y_ext;
    assign visible    = (s_q != 6'd0) && (y_ext <= l_ext) && (dy < 11'(SPR_H));
    assign last_pixel = (p_q == PW'(SPR_W - 1));
    assign last_index = (i_q == IW'(N_SPR - 1));

    // ROM data for last cycle's request arrives now; colour 0 is transparent
    // and anything past the right edge is dropped.
    assign wr_en = wr_valid_q && (bus.color_code != 4'd0) && (wr_addr_q < 11'(LINE_W));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            l_q        <= '0;
            i_q        <= '0;
            y_q        <= '0;
            x_q        <= '0;
            s_q        <= '0;
            row_q      <= '0;
            p_q        <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the pre-edge values of the others.
            state_q    <= state_d;
            wr_valid_q <= (state_q == S_FETCH);
            wr_addr_q  <= x_ext + 11'(p_q);
            case (state_q)
                S_IDLE:  if (bus.start) begin
                             l_q <= bus.line_num;
                             i_q <= '0;
                         end
                S_AWAIT: {y_q, x_q, s_q} <= bus.attr_data;
                S_CHECK: begin
                             row_q <= dy[9:0];
                             p_q   <= '0;
                         end
                S_FETCH: p_q <= p_q + PW'(1);
                S_NEXT:  if (!last_index) i_q <= i_q + IW'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave a latch behind.
        state_d       = state_q;
        bus.busy      = (state_q != S_IDLE);
        bus.done      = 1'b0;
        bus.attr_rd   = 1'b0;
        bus.attr_addr = '0;
        bus.n_sprite  = '0;
        bus.line      = '0;
        bus.pixel     = '0;
        bus.lb_we     = wr_en;
        bus.lb_addr   = wr_en ? wr_addr_q[9:0] : 10'd0;
        bus.lb_data   = wr_en ? bus.color_code : 4'd0;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_AREQ;
            S_AREQ:  begin
                         bus.attr_rd   = 1'b1;
                         bus.attr_addr = i_q;
                         state_d       = S_AWAIT;
                     end
            S_AWAIT: state_d = S_CHECK;
            S_CHECK: state_d = visible ? S_FETCH : S_NEXT;
            S_FETCH: begin
                         bus.n_sprite = s_q;
                         bus.line     = row_q;
                         bus.pixel    = 6'(p_q);
                         if (last_pixel) state_d = S_DRAIN;
                     end
            S_DRAIN: state_d = S_NEXT;
            S_NEXT:  state_d = last_index ? S_FIN : S_AREQ;
            S_FIN:   begin
                         bus.done = 1'b1;
                         state_d  = S_IDLE;
                     end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_sprite_line_renderer.sv
// Self-checking bench for sprite_line_renderer.
// A behavioural model walks the attribute table and pushes the ROM requests
// and buffer writes it expects; a negedge monitor pops and compares them as
// the DUT produces them. Each test task checks timing and totals inline.
module tb_sprite_line_renderer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sprite_line_renderer_if #(.N_SPR(32)) bus ();

    sprite_line_renderer #(.N_SPR(32), .SPR_W(32), .SPR_H(32), .LINE_W(640)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    typedef struct {
        logic [5:0] s;
        logic [9:0] row;
        logic [5:0] p;
    } req_t;

    typedef struct {
        logic [9:0] a;
        logic [3:0] c;
    } wr_t;

    req_t exp_req[$];
    wr_t  exp_wr[$];
    req_t mon_r;
    wr_t  mon_w;

    logic [25:0] attr_mem [0:31];
    logic [3:0]  lb_mem   [0:1023];
    int rom_mode;
    int checks = 0;
    int errors = 0;
    int req_seen = 0;
    int wr_seen = 0;
    int done_count = 0;

    function automatic logic [3:0] rom_color(input logic [5:0] s, input logic [9:0] row,
                                             input logic [5:0] p);
        int v;
        if (s == 6'd0) return 4'd0;
        case (rom_mode)
            1: return 4'hF;
            2: return (s == 6'd2 && p < 6'd4) ? 4'd0 : s[3:0];
            default: begin
                v = int'(s) * 5 + int'(row) * 3 + int'(p);
                return v[3:0];
            end
        endcase
    endfunction

    // Attribute table and sprite ROM: both answer one cycle after the request.
    always @(posedge clk) begin
        if (bus.attr_rd) bus.attr_data <= attr_mem[bus.attr_addr];
        else             bus.attr_data <= {10'd1023, 10'd0, 6'd7};
        bus.color_code <= rom_color(bus.n_sprite, bus.line, bus.pixel);
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (bus.n_sprite != 6'd0) begin
            req_seen++;
            checks++;
            if (exp_req.size() == 0) begin
                errors++;
                $display("FAIL rom_req_unexpected: got s=%0d row=%0d px=%0d, expected no request",
                         bus.n_sprite, bus.line, bus.pixel);
            end else begin
                mon_r = exp_req.pop_front();
                if ({bus.n_sprite, bus.line, bus.pixel} !== {mon_r.s, mon_r.row, mon_r.p}) begin
                    errors++;
                    $display("FAIL rom_req: got s=%0d row=%0d px=%0d, expected s=%0d row=%0d px=%0d",
                             bus.n_sprite, bus.line, bus.pixel, mon_r.s, mon_r.row, mon_r.p);
                end
            end
        end
        if (bus.lb_we === 1'b1) begin
            wr_seen++;
            checks++;
            lb_mem[bus.lb_addr] = bus.lb_data;
            if (exp_wr.size() == 0) begin
                errors++;
                $display("FAIL lb_write_unexpected: got addr=%0d data=%0d, expected no write",
                         bus.lb_addr, bus.lb_data);
            end else begin
                mon_w = exp_wr.pop_front();
                if ({bus.lb_addr, bus.lb_data} !== {mon_w.a, mon_w.c}) begin
                    errors++;
                    $display("FAIL lb_write: got addr=%0d data=%0d, expected addr=%0d data=%0d",
                             bus.lb_addr, bus.lb_data, mon_w.a, mon_w.c);
                end
            end
        end
        if (bus.done === 1'b1) done_count++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic clear_table();
        for (int i = 0; i < 32; i++) attr_mem[i] = '0;
    endtask

    // Reference model: painter's order over the whole table.
    task automatic build_expect(input int ln, output int vis);
        int y, x, s, row, a;
        logic [3:0] c;
        req_t r;
        wr_t  w;
        vis = 0;
        for (int i = 0; i < 32; i++) begin
            y = int'(attr_mem[i][25:16]);
            x = int'(attr_mem[i][15:6]);
            s = int'(attr_mem[i][5:0]);
            if (s != 0 && ln >= y && ln - y < 32) begin
                vis++;
                row = ln - y;
                for (int p = 0; p < 32; p++) begin
                    r.s = 6'(s); r.row = 10'(row); r.p = 6'(p);
                    exp_req.push_back(r);
                    c = rom_color(6'(s), 10'(row), 6'(p));
                    a = x + p;
                    if (c != 4'd0 && a < 640) begin
                        w.a = 10'(a); w.c = c;
                        exp_wr.push_back(w);
                    end
                end
            end
        end
    endtask

    // Pulses start and counts busy cycles up to and including the done cycle.
    task automatic run_line(input logic [9:0] ln, output int cyc, output bit timed_out);
        @(negedge clk);
        bus.line_num = ln;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        timed_out = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if (bus.busy) cyc++;
            if (bus.done) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        bus.line_num = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.lb_we, bus.attr_rd} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got busy/done/we/rd=%b, expected 0000",
                     {bus.busy, bus.done, bus.lb_we, bus.attr_rd});
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.lb_we, bus.attr_rd} !== 4'b0) begin
            errors++;
            $display("FAIL idle_ctrl: got busy/done/we/rd=%b, expected 0000",
                     {bus.busy, bus.done, bus.lb_we, bus.attr_rd});
        end
        checks++;
        if ({bus.n_sprite, bus.line, bus.pixel, bus.attr_addr} !== '0) begin
            errors++;
            $display("FAIL idle_req: got s=%0d line=%0d px=%0d aaddr=%0d, expected all 0",
                     bus.n_sprite, bus.line, bus.pixel, bus.attr_addr);
        end
        checks++;
        if ({bus.lb_addr, bus.lb_data} !== '0) begin
            errors++;
            $display("FAIL idle_lb: got addr=%0d data=%0d, expected 0", bus.lb_addr, bus.lb_data);
        end
    endtask

    task automatic test_single_sprite();
        int vis, cyc, r0;
        bit to;
        clear_table();
        attr_mem[0] = {10'd100, 10'd200, 6'd1};
        rom_mode = 0;
        r0 = req_seen;
        build_expect(105, vis);
        run_line(10'd105, cyc, to);
        checks++;
        if (to || cyc != 162) begin
            errors++;
            $display("FAIL single_cycles: got %0d (timeout=%0d), expected 162", cyc, to);
        end
        checks++;
        if (req_seen - r0 != 32) begin
            errors++;
            $display("FAIL single_req_count: got %0d, expected 32", req_seen - r0);
        end
        checks++;
        if (exp_req.size() != 0 || exp_wr.size() != 0) begin
            errors++;
            $display("FAIL single_leftover: got %0d req %0d wr pending, expected 0",
                     exp_req.size(), exp_wr.size());
        end
    endtask

    task automatic test_row_bounds();
        int lines [3] = '{99, 132, 131};
        int cycs  [3] = '{129, 129, 162};
        int reqs  [3] = '{0, 0, 32};
        int vis, cyc, r0;
        bit to;
        clear_table();
        attr_mem[0] = {10'd100, 10'd200, 6'd1};
        rom_mode = 0;
        for (int t = 0; t < 3; t++) begin
            r0 = req_seen;
            build_expect(lines[t], vis);
            run_line(10'(lines[t]), cyc, to);
            checks++;
            if (to || cyc != cycs[t]) begin
                errors++;
                $display("FAIL bounds_cycles line %0d: got %0d, expected %0d", lines[t], cyc, cycs[t]);
            end
            checks++;
            if (req_seen - r0 != reqs[t]) begin
                errors++;
                $display("FAIL bounds_req_count line %0d: got %0d, expected %0d",
                         lines[t], req_seen - r0, reqs[t]);
            end
            checks++;
            if (exp_req.size() != 0 || exp_wr.size() != 0) begin
                errors++;
                $display("FAIL bounds_leftover line %0d: got %0d/%0d pending, expected 0",
                         lines[t], exp_req.size(), exp_wr.size());
            end
        end
    endtask

    task automatic test_clip();
        int vis, cyc, w0;
        bit to;
        clear_table();
        attr_mem[0] = {10'd100, 10'd620, 6'd1};
        rom_mode = 1;
        w0 = wr_seen;
        build_expect(105, vis);
        run_line(10'd105, cyc, to);
        checks++;
        if (to || cyc != 162) begin
            errors++;
            $display("FAIL clip_cycles: got %0d, expected 162", cyc);
        end
        checks++;
        if (wr_seen - w0 != 20) begin
            errors++;
            $display("FAIL clip_writes: got %0d, expected 20", wr_seen - w0);
        end
        checks++;
        if (exp_wr.size() != 0) begin
            errors++;
            $display("FAIL clip_leftover: got %0d pending, expected 0", exp_wr.size());
        end
    endtask

    task automatic test_overlap();
        int vis, cyc;
        logic [3:0] want;
        bit to;
        clear_table();
        attr_mem[0] = {10'd100, 10'd10, 6'd1};
        attr_mem[1] = {10'd100, 10'd20, 6'd2};
        rom_mode = 2;
        for (int a = 0; a < 1024; a++) lb_mem[a] = 4'd0;
        build_expect(105, vis);
        run_line(10'd105, cyc, to);
        checks++;
        if (to || cyc != 195) begin
            errors++;
            $display("FAIL overlap_cycles: got %0d, expected 195", cyc);
        end
        for (int a = 5; a < 60; a++) begin
            if (a >= 24 && a <= 51)      want = 4'd2;
            else if (a >= 10 && a <= 41) want = 4'd1;
            else                         want = 4'd0;
            checks++;
            if (lb_mem[a] !== want) begin
                errors++;
                $display("FAIL overlap_buf[%0d]: got %0d, expected %0d", a, lb_mem[a], want);
            end
        end
    endtask

    task automatic test_handshake();
        int vis, cyc, d0;
        bit to;
        clear_table();
        attr_mem[0] = {10'd100, 10'd200, 6'd1};
        rom_mode = 0;
        d0 = done_count;
        build_expect(105, vis);
        @(negedge clk);
        bus.line_num = 10'd105;
        bus.start = 1'b1;
        cyc = 0;
        to = 1'b1;
        for (int k = 1; k < 3000; k++) begin
            @(negedge clk);
            bus.start = (k < 5) || (k == 10);
            bus.line_num = (k == 10) ? 10'd120 : 10'd110;
            if (bus.busy) cyc++;
            if (bus.done) begin
                to = 1'b0;
                bus.start = 1'b1;   // start during FIN must be ignored
                break;
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
        repeat (40) @(negedge clk);
        checks++;
        if (to || cyc != 162) begin
            errors++;
            $display("FAIL handshake_cycles: got %0d, expected 162", cyc);
        end
        checks++;
        if (done_count - d0 != 1) begin
            errors++;
            $display("FAIL handshake_done_count: got %0d, expected 1", done_count - d0);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL handshake_idle: got busy=%b, expected 0", bus.busy);
        end
        checks++;
        if (exp_req.size() != 0 || exp_wr.size() != 0) begin
            errors++;
            $display("FAIL handshake_leftover: got %0d/%0d pending, expected 0",
                     exp_req.size(), exp_wr.size());
        end
    endtask

    task automatic test_reset_abort();
        int vis, cyc, d0;
        bit to;
        clear_table();
        attr_mem[10] = {10'd100, 10'd300, 6'd3};
        rom_mode = 0;
        d0 = done_count;
        build_expect(105, vis);
        @(negedge clk);
        bus.line_num = 10'd105;
        bus.start = 1'b1;
        for (int k = 1; k <= 51; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (k == 50) reset = 1'b1;
            if (k == 51) reset = 1'b0;
        end
        checks++;
        if ({bus.busy, bus.lb_we, bus.done} !== 3'b000) begin
            errors++;
            $display("FAIL abort_outputs: got busy/we/done=%b, expected 000",
                     {bus.busy, bus.lb_we, bus.done});
        end
        exp_req.delete();
        exp_wr.delete();
        repeat (40) @(negedge clk);
        checks++;
        if (done_count != d0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_quiet: got %0d done pulses busy=%b, expected 0 and 0",
                     done_count - d0, bus.busy);
        end
        build_expect(105, vis);
        run_line(10'd105, cyc, to);
        checks++;
        if (to || cyc != 162) begin
            errors++;
            $display("FAIL abort_rerun_cycles: got %0d, expected 162", cyc);
        end
        checks++;
        if (done_count - d0 != 1 || exp_req.size() != 0 || exp_wr.size() != 0) begin
            errors++;
            $display("FAIL abort_rerun: got %0d done, %0d/%0d pending, expected 1, 0/0",
                     done_count - d0, exp_req.size(), exp_wr.size());
        end
    endtask

    task automatic test_empty();
        int vis, cyc, w0, r0;
        bit to;
        clear_table();
        rom_mode = 1;
        w0 = wr_seen;
        r0 = req_seen;
        build_expect(105, vis);
        run_line(10'd105, cyc, to);
        checks++;
        if (to || cyc != 129) begin
            errors++;
            $display("FAIL empty_cycles: got %0d, expected 129", cyc);
        end
        checks++;
        if (wr_seen != w0 || req_seen != r0) begin
            errors++;
            $display("FAIL empty_traffic: got %0d writes %0d reqs, expected 0",
                     wr_seen - w0, req_seen - r0);
        end
    endtask

    initial begin
        rom_mode = 0;
        clear_table();
        test_reset();
        test_single_sprite();
        test_row_bounds();
        test_clip();
        test_overlap();
        test_handshake();
        test_reset_abort();
        test_empty();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
